// File: rtl/uncache_mem_bridge.sv
// Bridges one uncached scalar LSU access onto a single 8-byte-aligned bus beat,
// with lane steering, read-data alignment, bus timeout and a sticky error flag.
module uncache_mem_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned CNT_W          = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_vld_i,
  output logic        req_rdy_o,
  input  logic        req_write_i,
  input  logic [2:0]  req_size_i,
  input  logic [63:0] req_addr_i,
  input  logic [63:0] req_wdata_i,
  output logic        resp_vld_o,
  input  logic        resp_rdy_i,
  output logic [63:0] resp_data_o,
  output logic        bus_req_vld_o,
  input  logic        bus_req_rdy_i,
  output logic        bus_we_o,
  output logic [63:0] bus_addr_o,
  output logic [63:0] bus_wdata_o,
  output logic [7:0]  bus_wstrb_o,
  input  logic        bus_rsp_vld_i,
  input  logic [63:0] bus_rsp_data_i,
  input  logic        bus_rsp_err_i,
  output logic        err_o,
  input  logic        err_clr_i
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic              init_q;
  logic              we_q;
  logic [1:0]        size_q;
  logic [2:0]        off_q;
  logic [63:0]       addr_q, wdata_q;
  logic [7:0]        strb_q;
  logic [63:0]       rdata_q, rdata_d;
  logic              err_q, err_d, err_set;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              accept, timeout;

  logic [2:0]        lo_mask, off_in;
  logic [7:0]        strb_base, strb_in;
  logic [63:0]       wmask, wdata_in;
  logic              misaligned;

  function automatic logic [63:0] size_mask(input logic [1:0] sz);
    unique case (sz)
      2'd0:    size_mask = 64'h0000_0000_0000_00FF;
      2'd1:    size_mask = 64'h0000_0000_0000_FFFF;
      2'd2:    size_mask = 64'h0000_0000_FFFF_FFFF;
      default: size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  // Request decode: offset is the address rounded down to the access size.
  always_comb begin
    lo_mask   = 3'b000;
    strb_base = 8'h01;
    unique case (req_size_i[1:0])
      2'd0:    begin lo_mask = 3'b000; strb_base = 8'h01; end
      2'd1:    begin lo_mask = 3'b001; strb_base = 8'h03; end
      2'd2:    begin lo_mask = 3'b011; strb_base = 8'h0F; end
      default: begin lo_mask = 3'b111; strb_base = 8'hFF; end
    endcase
    wmask      = size_mask(req_size_i[1:0]);
    off_in     = req_addr_i[2:0] & ~lo_mask;
    misaligned = |(req_addr_i[2:0] & lo_mask);
    strb_in    = strb_base << off_in;
    wdata_in   = (req_wdata_i & wmask) << {off_in, 3'b000};
  end

  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_set = 1'b0;
    accept  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_vld_i && init_q) begin
          accept  = 1'b1;
          state_d = StReq;
          cnt_d   = '0;
          err_set = misaligned;
        end
      end
      StReq: begin
        cnt_d = cnt_q + 1'b1;
        if (bus_req_rdy_i) begin
          state_d = StWait;
        end else if (timeout) begin
          err_set = 1'b1;
          if (we_q) begin
            state_d = StIdle;
          end else begin
            state_d = StResp;
            rdata_d = '1;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q + 1'b1;
        if (bus_rsp_vld_i) begin
          err_set = bus_rsp_err_i;
          if (we_q) begin
            state_d = StIdle;
          end else begin
            state_d = StResp;
            rdata_d = (bus_rsp_data_i >> {off_q, 3'b000}) & size_mask(size_q);
          end
        end else if (timeout) begin
          err_set = 1'b1;
          if (we_q) begin
            state_d = StIdle;
          end else begin
            state_d = StResp;
            rdata_d = '1;
          end
        end
      end
      StResp: begin
        if (resp_rdy_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    err_d = err_set ? 1'b1 : (err_clr_i ? 1'b0 : err_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      init_q  <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      init_q  <= 1'b1;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      size_q  <= 2'd0;
      off_q   <= 3'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
    end else if (accept) begin
      we_q    <= req_write_i;
      size_q  <= req_size_i[1:0];
      off_q   <= off_in;
      addr_q  <= {req_addr_i[63:3], 3'b000};
      wdata_q <= wdata_in;
      strb_q  <= strb_in;
    end
  end

  // init_q keeps req_rdy_o low while reset is asserted.
  assign req_rdy_o     = (state_q == StIdle) && init_q;
  assign bus_req_vld_o = (state_q == StReq);
  assign resp_vld_o    = (state_q == StResp);
  assign resp_data_o   = rdata_q;
  assign bus_we_o      = we_q;
  assign bus_addr_o    = addr_q;
  assign bus_wdata_o   = wdata_q;
  assign bus_wstrb_o   = strb_q;
  assign err_o         = err_q;

endmodule
